// File: rtl/frame_min_max_pkg.sv
// Shared definitions for the frame min/max tracker: sample width and control states.
package frame_min_max_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } state_e;

endpackage

// File: rtl/comparator_8_bit.sv
// Unsigned magnitude comparator: flags a_i greater/equal/less than b_i.
module comparator_8_bit
   import frame_min_max_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  gt_o,
   output logic                  eq_o,
   output logic                  lt_o
);

   assign gt_o = (a_i > b_i);
   assign eq_o = (a_i == b_i);
   assign lt_o = (a_i < b_i);

endmodule

// File: rtl/frame_min_max_tracker.sv
// Tracks max/min of an unsigned 8-bit sample frame, plus first-occurrence indices,
// and returns the result over a valid/ready handshake.
module frame_min_max_tracker
   import frame_min_max_pkg::*;
#(
   parameter  int unsigned FRAME_LEN = 16,
   localparam int unsigned IDX_WIDTH = $clog2(FRAME_LEN)
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  start_in,
   input  logic                  abort_in,
   input  logic                  s_valid_in,
   input  logic [DATA_WIDTH-1:0] s_data_in,
   output logic                  s_ready_out,
   output logic                  r_valid_out,
   input  logic                  r_ready_in,
   output logic [DATA_WIDTH-1:0] max_out,
   output logic [DATA_WIDTH-1:0] min_out,
   output logic [IDX_WIDTH-1:0]  max_idx_out,
   output logic [IDX_WIDTH-1:0]  min_idx_out,
   output logic                  busy_out
);

   localparam int unsigned            CNT_WIDTH = IDX_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0]   LAST_IDX  = CNT_WIDTH'(FRAME_LEN - 1);

   state_e                  state_q,   state_d;
   logic [CNT_WIDTH-1:0]    cnt_q,     cnt_d;
   logic                    s_ready_q, s_ready_d;
   logic                    r_valid_q, r_valid_d;
   logic                    busy_q,    busy_d;
   logic [DATA_WIDTH-1:0]   max_q,     max_d;
   logic [DATA_WIDTH-1:0]   min_q,     min_d;
   logic [IDX_WIDTH-1:0]    max_idx_q, max_idx_d;
   logic [IDX_WIDTH-1:0]    min_idx_q, min_idx_d;

   logic max_gt, max_eq, max_lt;
   logic min_gt, min_eq, min_lt;
   logic accept;
   logic first_sample;
   logic upd_max;
   logic upd_min;
   logic [IDX_WIDTH-1:0] cur_idx;

   comparator_8_bit u_cmp_max (
      .a_i  (s_data_in),
      .b_i  (max_q),
      .gt_o (max_gt),
      .eq_o (max_eq),
      .lt_o (max_lt)
   );

   comparator_8_bit u_cmp_min (
      .a_i  (s_data_in),
      .b_i  (min_q),
      .gt_o (min_gt),
      .eq_o (min_eq),
      .lt_o (min_lt)
   );

   // Abort must block a sample in the same cycle, so it gates the registered ready.
   assign s_ready_out  = s_ready_q & ~abort_in;
   assign accept       = s_valid_in & s_ready_out;
   assign first_sample = (cnt_q == '0);
   assign cur_idx      = cnt_q[IDX_WIDTH-1:0];
   assign upd_max      = max_gt & ~(max_eq | max_lt);
   assign upd_min      = min_lt & ~(min_eq | min_gt);

   assign r_valid_out  = r_valid_q;
   assign busy_out     = busy_q;
   assign max_out      = max_q;
   assign min_out      = min_q;
   assign max_idx_out  = max_idx_q;
   assign min_idx_out  = min_idx_q;

   // Next-state and next-output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      s_ready_d = s_ready_q;
      r_valid_d = r_valid_q;
      busy_d    = busy_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d   = ACCUM;
               cnt_d     = '0;
               s_ready_d = 1'b1;
               busy_d    = 1'b1;
            end
         end

         ACCUM: begin
            if (abort_in) begin
               state_d   = IDLE;
               cnt_d     = '0;
               s_ready_d = 1'b0;
               r_valid_d = 1'b0;
               busy_d    = 1'b0;
            end else if (accept) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               if (first_sample) begin
                  max_d     = s_data_in;
                  min_d     = s_data_in;
                  max_idx_d = '0;
                  min_idx_d = '0;
               end else begin
                  if (upd_max) begin
                     max_d     = s_data_in;
                     max_idx_d = cur_idx;
                  end
                  if (upd_min) begin
                     min_d     = s_data_in;
                     min_idx_d = cur_idx;
                  end
               end
               if (cnt_q == LAST_IDX) begin
                  state_d   = RESULT;
                  s_ready_d = 1'b0;
                  r_valid_d = 1'b1;
               end
            end
         end

         RESULT: begin
            if (abort_in) begin
               state_d   = IDLE;
               cnt_d     = '0;
               r_valid_d = 1'b0;
               busy_d    = 1'b0;
            end else if (r_ready_in) begin
               state_d   = IDLE;
               r_valid_d = 1'b0;
               busy_d    = 1'b0;
            end
         end

         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            s_ready_d = 1'b0;
            r_valid_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
         r_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         max_q     <= '0;
         min_q     <= '0;
         max_idx_q <= '0;
         min_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
         r_valid_q <= r_valid_d;
         busy_q    <= busy_d;
         max_q     <= max_d;
         min_q     <= min_d;
         max_idx_q <= max_idx_d;
         min_idx_q <= min_idx_d;
      end
   end

endmodule

// File: doc/frame_min_max_tracker.md
Name: frame_min_max_tracker

Overview:
Streaming consumer of unsigned 8-bit samples. Over a frame of FRAME_LEN accepted samples it tracks the running maximum and minimum, and the index of each. It presents the result through a valid/ready handshake. All magnitude decisions come from two comparator_8_bit instances: sample vs current max, and sample vs current min. The block sits directly downstream of those comparators and consumes their greater/equal/less flags.

Parameters:
FRAME_LEN, 16, samples per frame; legal range 2..256.
IDX_WIDTH, $clog2(FRAME_LEN), width of index outputs; derived, not overridden.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  single-cycle request to begin a frame; honoured only in IDLE
abort_in  input  1  synchronous frame abort; returns to IDLE
s_valid_in  input  1  sample valid
s_data_in  input  8  unsigned sample
s_ready_out  output  1  sample accept
r_valid_out  output  1  result valid
r_ready_in  input  1  result consumed
max_out  output  8  frame maximum
min_out  output  8  frame minimum
max_idx_out  output  IDX_WIDTH  index of first occurrence of maximum
min_idx_out  output  IDX_WIDTH  index of first occurrence of minimum
busy_out  output  1  high in ACCUM or RESULT

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low (rst_n_in).
- Reset values: state IDLE; all outputs 0, including s_ready_out and r_valid_out; sample counter 0.
- State IDLE:
  - s_ready_out=0 and r_valid_out=0.
  - start_in=1 -> ACCUM next cycle; counter cleared.
- State ACCUM:
  - s_ready_out=1 (registered, asserted in the first ACCUM cycle); busy_out=1.
  - An accept is a cycle with s_valid_in & s_ready_out.
  - Accept at index 0: max=min=s_data_in; max_idx=min_idx=0.
  - Accept at index k>0, max: if the comparator against max reports greater, max=data and max_idx=k. Equal or less leaves max unchanged, so ties keep the earliest index.
  - Accept at index k>0, min: if the comparator against min reports less, min=data and min_idx=k. Equal or greater leaves min unchanged.
  - Both updates may occur in the same cycle (only possible at k=0).
  - Counter increments on every accept.
  - On the accept at index FRAME_LEN-1: -> RESULT next cycle, and s_ready_out deasserts in that same next cycle. No extra sample is ever accepted.
  - start_in is ignored in ACCUM.
- State RESULT:
  - r_valid_out=1; max/min/idx outputs hold stable until the handshake completes; s_ready_out=0.
  - Latency: r_valid_out rises exactly 1 cycle after the final accept.
  - r_valid_out & r_ready_in -> IDLE next cycle. r_valid_out drops, outputs retain their last values, and busy_out drops.
  - start_in coincident with the handshake is ignored; a new start is required in IDLE.
- abort_in:
  - Highest priority in ACCUM and RESULT: -> IDLE next cycle; counter cleared; r_valid_out=0.
  - Any sample presented in the abort cycle is not accepted (s_ready_out is forced low combinationally by abort_in).
- Reset mid-frame: immediate return to reset values; any partial frame is discarded.
- s_valid_in gaps in ACCUM stall with no state change.
- All arithmetic is unsigned; the counter is IDX_WIDTH+1 bits, so it never wraps within a frame.

Decomposition:
- Package frame_min_max_pkg: DATA_WIDTH=8 localparam, and state enum typedef {IDLE, ACCUM, RESULT} (2-bit).
- Sub-module: the existing comparator_8_bit, instantiated twice. No new sub-module is needed.
- DATA_WIDTH is fixed at 8 and is not a parameter.

Test Plan:
- Frame 0x10,0x80,0x05,0x80,0x7F,… (FRAME_LEN=5) -> max=0x80 idx=1; min=0x05 idx=2; r_valid exactly 1 cycle after the 5th accept.
- All samples 0x42 -> max=min=0x42, both idx=0. Separately: 0x00 and 0xFF at indices 3 and 4 -> min=0x00 idx=3, max=0xFF idx=4.
- Random s_valid gaps plus r_ready held low 10 cycles in RESULT -> outputs stable, no extra sample accepted, s_ready low throughout RESULT.
- abort_in asserted after 2 accepts, with a valid sample present in the same cycle -> IDLE next cycle, sample not accepted, r_valid never rises; a following start_in yields a correct fresh frame.
- rst_n_in asserted asynchronously mid-ACCUM and mid-RESULT -> all outputs 0 immediately; start_in ignored while in ACCUM.
- Back-to-back frames: result handshake, start on the next cycle, second frame -> results reflect the second frame only.
